mux_scanner: RTL and testbench
==============================

# mux_scanner

Parametrised time-division scanning multiplexer: selects one of `N_CH` input channels of `W` bits each and presents it on a registered output, either auto-scanning channels round-robin with a programmable dwell time or following a manual select. It is the sequential successor to the team's fixed 16:1 combinational multiplexer. It sits between banks of sampled inputs and a single-lane consumer such as a display, serialiser or capture block.

## Interface
- `N_CH`, 16, number of input channels, ≥2
- `W`, 1, bits per channel
- `DWELL_W`, 8, width of the dwell-count field
- `clk` input 1, single clock, rising edge
- `rst` input 1, synchronous, active-high reset
- `in` input `N_CH*W`, channel data; channel k occupies `in[k*W +: W]`
- `mode` input 1, 0 = auto scan, 1 = manual; sampled on `start`
- `man_sel` input `$clog2(N_CH)`, manual channel index; read every cycle in manual mode
- `dwell` input `DWELL_W`, cycles per channel minus one; read live
- `start` input 1, pulse that begins or restarts a scan
- `stop` input 1, pulse that ends a scan
- `out` output `W`, registered selected data
- `out_ch` output `$clog2(N_CH)`, channel index `out` came from
- `out_valid` output 1, `out`/`out_ch` meaningful
- `wrap` output 1, one-cycle pulse when auto scan returns to the lowest channel
- `busy` output 1, high in RUN

## Operation
- States: IDLE, RUN.
- In IDLE, `busy=0` and `out_valid=0`. `out` and `out_ch` hold their last values.
- `start` in IDLE or RUN does the following, then enters or re-enters RUN:
  - latches `mode`;
  - sets `ch` to 0 in auto mode, or to `man_sel` in manual mode;
  - sets `dwell_cnt` to 0.
- `stop` enters IDLE. If `start` and `stop` occur in the same cycle, `stop` wins.
- In RUN, every cycle: `out <= in[ch*W +: W]`, `out_ch <= ch`, `out_valid <= 1`.
- Auto mode:
  - `dwell_cnt` increments each cycle.
  - When `dwell_cnt >= dwell`, `ch` advances to the next channel and `dwell_cnt` clears. Using `>=` means that lowering `dwell` mid-dwell advances the channel immediately.
  - After `N_CH-1` the next channel is 0, and `wrap` pulses in that cycle.
  - `dwell=0` advances the channel every cycle.
- Manual mode: `ch <= man_sel` every cycle, `dwell_cnt` is unused, and `wrap` stays 0.
- An out-of-range `man_sel` (when `N_CH` is not a power of 2) is clamped to `N_CH-1`.

## Timing
- Reset values: `out=0`, `out_ch=0`, `out_valid=0`, `wrap=0`, `busy=0`; state = IDLE, `ch=0`, `dwell_cnt=0`.
- `rst` overrides `start` and `stop`, including when asserted mid-scan.
- Latency:
  - `out` at edge t+1 reflects `in` and `ch` sampled at edge t.
  - `start` at edge t gives `busy=1` after edge t; the first `out_valid=1` appears after edge t+1, carrying channel 0 (auto) or `man_sel` (manual).
  - Each channel is presented for exactly `dwell+1` consecutive valid cycles when `dwell` is static.
- `stop` at edge t: `busy=0` after edge t, `out_valid=0` after edge t+1, and the final sample completes.
- `wrap` is registered and aligned with the cycle in which `out_ch` first shows 0 after a wrap.

## Configuration
- Macro: `MUX_SCANNER_SKIP_MASK_EN`.
- Defined:
  - Adds input `ch_mask` [`N_CH`] (1 = enabled), read live.
  - Auto scan advances to the next enabled channel above `ch`, searching with wrap-around. `wrap` pulses when the search crosses from a higher index to a lower one.
  - On `start`, `ch` is the lowest enabled channel.
  - If `ch_mask` is all zero: `out_valid=0`, `ch` holds, the block stays in RUN, and it resumes once any bit sets.
  - Manual mode ignores `ch_mask`.
- Undefined: there is no `ch_mask` port, and every channel is scanned in order.

## Structure
- Shared package `mux_pkg`:
  - state enum (`ST_IDLE`, `ST_RUN`);
  - `MODE_AUTO`/`MODE_MANUAL` constants;
  - index-width helper function.
- One sub-module, `mux_next_ch`: a combinational rotate-priority search returning the next channel index and a wrap flag. It uses the mask when the macro is defined and is a plain increment-with-wrap otherwise.

## Test plan
- `N_CH=16`, `W=1`, `in=16'hAAAA`, auto, `dwell=0`, start → `out_ch` goes 0..15; `out` alternates 0,1,…; `wrap` pulses when `out_ch` returns to 0.
- `N_CH=4`, `W=8`, `in=32'h44332211`, auto, `dwell=2` → each byte held 3 valid cycles (11,11,11,22,…); lowering `dwell` to 0 mid-dwell advances the channel on the next edge.
- Manual mode, `man_sel` stepping 3,1,2 → `out_ch` follows with a one-cycle lag and `wrap` stays 0; `man_sel`=5 with `N_CH=5` → clamped to 4.
- Boundary events:
  - `start` and `stop` in the same cycle while in IDLE → block stays IDLE with `out_valid=0`.
  - `start` at channel 9 while in RUN → restarts, and the next valid sample is channel 0.
  - `rst` mid-scan → all outputs return to reset values the following cycle.
- With `MUX_SCANNER_SKIP_MASK_EN`:
  - `ch_mask=16'h8101` → scan is 0,8,15,0 with `wrap` on each return to 0.
  - `ch_mask=0` → `out_valid=0` and `busy=1`.
  - Setting bit 4 → scan resumes at channel 4.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and helpers for the mux_scanner block and its channel-search sub-module.
package mux_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic MODE_AUTO   = 1'b0;
    localparam logic MODE_MANUAL = 1'b1;

    // Index width for n channels; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_next_ch.sv
// Combinational next-channel search with wrap detection for mux_scanner.
// With MUX_SCANNER_SKIP_MASK_EN defined it skips disabled channels; otherwise a plain increment.
module mux_next_ch
    import mux_pkg::*;
#(
    parameter int N_CH = 16,
    parameter int CW   = idx_w(N_CH)
) (
    input  logic [CW-1:0]   i_ch,
`ifdef MUX_SCANNER_SKIP_MASK_EN
    input  logic [N_CH-1:0] i_mask,
`endif
    output logic [CW-1:0]   o_next,
    output logic            o_wrap,
    output logic            o_found
);

`ifdef MUX_SCANNER_SKIP_MASK_EN
    // Priority chain from the nearest candidate above i_ch outward, wrapping back to i_ch itself.
    for (genvar off = 1; off <= N_CH; off++) begin : g_search
        logic [CW-1:0] w_cand;
        logic [CW-1:0] w_pick;
        logic          w_hit;
        assign w_cand = CW'((int'(i_ch) + off) % N_CH);
        if (off == N_CH) begin : g_last
            assign w_hit  = i_mask[w_cand];
            assign w_pick = w_cand;
        end else begin : g_mid
            assign w_hit  = i_mask[w_cand] | g_search[off+1].w_hit;
            assign w_pick = i_mask[w_cand] ? w_cand : g_search[off+1].w_pick;
        end
    end

    assign o_found = g_search[1].w_hit;
    assign o_next  = o_found ? g_search[1].w_pick : i_ch;
    assign o_wrap  = o_found && (g_search[1].w_pick <= i_ch);
`else
    localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

    assign o_found = 1'b1;
    assign o_wrap  = (i_ch >= LAST_CH);
    assign o_next  = o_wrap ? '0 : i_ch + CW'(1);
`endif

endmodule

// File: rtl/mux_scanner.sv
// Time-division scanning multiplexer: auto round-robin with programmable dwell, or manual select.
// Optional feature macro MUX_SCANNER_SKIP_MASK_EN adds a live ch_mask that auto scan honours.
module mux_scanner
    import mux_pkg::*;
#(
    parameter int  N_CH    = 16,
    parameter int  W       = 1,
    parameter int  DWELL_W = 8,
    localparam int CW      = idx_w(N_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH*W-1:0]   in,
    input  logic                mode,
    input  logic [CW-1:0]       man_sel,
    input  logic [DWELL_W-1:0]  dwell,
    input  logic                start,
    input  logic                stop,
`ifdef MUX_SCANNER_SKIP_MASK_EN
    input  logic [N_CH-1:0]     ch_mask,
`endif
    output logic [W-1:0]        out,
    output logic [CW-1:0]       out_ch,
    output logic                out_valid,
    output logic                wrap,
    output logic                busy
);

    localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

    state_e             r_state, w_state_next;
    logic               r_mode, w_mode_next;
    logic [CW-1:0]      r_ch, w_ch_next;
    logic [DWELL_W-1:0] r_dwell_cnt, w_dwell_next;
    logic               r_wrapped, w_wrapped_next;
    logic [W-1:0]       r_out;
    logic [CW-1:0]      r_out_ch;
    logic               r_out_valid, r_wrap;

    logic [W-1:0]       w_chan [N_CH];
    logic [CW-1:0]      w_man_ch, w_search_from, w_adv_ch;
    logic               w_adv_wrap, w_found, w_cur_en, w_valid_next;

    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        assign w_chan[k] = in[k*W +: W];
    end

    if ((1 << CW) > N_CH) begin : g_clamp
        assign w_man_ch = (man_sel > LAST_CH) ? LAST_CH : man_sel;
    end else begin : g_no_clamp
        assign w_man_ch = man_sel;
    end

`ifdef MUX_SCANNER_SKIP_MASK_EN
    assign w_cur_en = ch_mask[r_ch];
`else
    assign w_cur_en = 1'b1;
`endif

    // Searching "after the last channel" yields the lowest enabled channel, which start needs.
    assign w_search_from = start ? LAST_CH : r_ch;

    mux_next_ch #(
        .N_CH (N_CH),
        .CW   (CW)
    ) u_next_ch (
        .i_ch    (w_search_from),
`ifdef MUX_SCANNER_SKIP_MASK_EN
        .i_mask  (ch_mask),
`endif
        .o_next  (w_adv_ch),
        .o_wrap  (w_adv_wrap),
        .o_found (w_found)
    );

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        w_state_next   = r_state;
        w_mode_next    = r_mode;
        w_ch_next      = r_ch;
        w_dwell_next   = r_dwell_cnt;
        w_wrapped_next = 1'b0;
        if (stop) begin
            w_state_next = ST_IDLE;
        end else if (start) begin
            w_state_next = ST_RUN;
            w_mode_next  = mode;
            w_ch_next    = (mode == MODE_MANUAL) ? w_man_ch : w_adv_ch;
            w_dwell_next = '0;
        end else if (r_state == ST_RUN) begin
            if (r_mode == MODE_MANUAL) begin
                w_ch_next = w_man_ch;
            end else if (!w_cur_en || (r_dwell_cnt >= dwell)) begin
                // A channel disabled under it is left at once; no enabled channel at all holds ch.
                w_dwell_next = '0;
                if (w_found) begin
                    w_ch_next      = w_adv_ch;
                    w_wrapped_next = w_adv_wrap;
                end
            end else begin
                w_dwell_next = r_dwell_cnt + DWELL_W'(1);
            end
        end
    end

    assign w_valid_next = (r_state == ST_RUN) && ((r_mode == MODE_MANUAL) || w_cur_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_AUTO;
            r_ch        <= '0;
            r_dwell_cnt <= '0;
            r_wrapped   <= 1'b0;
            r_out       <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state     <= w_state_next;
            r_mode      <= w_mode_next;
            r_ch        <= w_ch_next;
            r_dwell_cnt <= w_dwell_next;
            r_wrapped   <= w_wrapped_next;
            r_out_valid <= w_valid_next;
            r_wrap      <= (r_state == ST_RUN) && r_wrapped;
            if (r_state == ST_RUN) begin
                r_out    <= w_chan[r_ch];
                r_out_ch <= r_ch;
            end
        end
    end

    assign out       = r_out;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;
    assign wrap      = r_wrap;
    assign busy      = (r_state == ST_RUN);

endmodule

// File: tb/tb_mux_scanner.sv
// Directed self-checking bench for mux_scanner: 16x1 auto scan, 4x8 dwell, 5x8 manual with clamp.
module tb_mux_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks   = 0;
    int   failures = 0;

    // Instance A: N_CH=16, W=1
    logic [15:0] a_in;
    logic        a_mode, a_start, a_stop;
    logic [3:0]  a_man_sel;
    logic [7:0]  a_dwell;
    logic        a_out, a_out_valid, a_wrap, a_busy;
    logic [3:0]  a_out_ch;
    // Instance B: N_CH=4, W=8
    logic [31:0] b_in;
    logic        b_mode, b_start, b_stop;
    logic [1:0]  b_man_sel;
    logic [7:0]  b_dwell;
    logic [7:0]  b_out;
    logic        b_out_valid, b_wrap, b_busy;
    logic [1:0]  b_out_ch;
    // Instance C: N_CH=5, W=8
    logic [39:0] c_in;
    logic        c_mode, c_start, c_stop;
    logic [2:0]  c_man_sel;
    logic [7:0]  c_dwell;
    logic [7:0]  c_out;
    logic        c_out_valid, c_wrap, c_busy;
    logic [2:0]  c_out_ch;
`ifdef MUX_SCANNER_SKIP_MASK_EN
    logic [15:0] a_mask;
    logic [3:0]  b_mask;
    logic [4:0]  c_mask;
`endif

    mux_scanner #(.N_CH(16), .W(1), .DWELL_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .in(a_in), .mode(a_mode), .man_sel(a_man_sel),
        .dwell(a_dwell), .start(a_start), .stop(a_stop),
`ifdef MUX_SCANNER_SKIP_MASK_EN
        .ch_mask(a_mask),
`endif
        .out(a_out), .out_ch(a_out_ch), .out_valid(a_out_valid), .wrap(a_wrap), .busy(a_busy)
    );

    mux_scanner #(.N_CH(4), .W(8), .DWELL_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .in(b_in), .mode(b_mode), .man_sel(b_man_sel),
        .dwell(b_dwell), .start(b_start), .stop(b_stop),
`ifdef MUX_SCANNER_SKIP_MASK_EN
        .ch_mask(b_mask),
`endif
        .out(b_out), .out_ch(b_out_ch), .out_valid(b_out_valid), .wrap(b_wrap), .busy(b_busy)
    );

    mux_scanner #(.N_CH(5), .W(8), .DWELL_W(8)) u_dut_c (
        .clk(clk), .rst(rst), .in(c_in), .mode(c_mode), .man_sel(c_man_sel),
        .dwell(c_dwell), .start(c_start), .stop(c_stop),
`ifdef MUX_SCANNER_SKIP_MASK_EN
        .ch_mask(c_mask),
`endif
        .out(c_out), .out_ch(c_out_ch), .out_valid(c_out_valid), .wrap(c_wrap), .busy(c_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_b [6];
        exp_b = '{8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22};

        rst = 1'b1;
        a_in = 16'hAAAA; a_mode = 1'b0; a_man_sel = '0; a_dwell = '0; a_start = 1'b0; a_stop = 1'b0;
        b_in = 32'h44332211; b_mode = 1'b0; b_man_sel = '0; b_dwell = '0; b_start = 1'b0; b_stop = 1'b0;
        c_in = 40'h5544332211; c_mode = 1'b0; c_man_sel = '0; c_dwell = '0; c_start = 1'b0; c_stop = 1'b0;
`ifdef MUX_SCANNER_SKIP_MASK_EN
        a_mask = '1; b_mask = '1; c_mask = '1;
`endif
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        check("rst_a_out", a_out, 0);
        check("rst_a_out_ch", a_out_ch, 0);
        check("rst_a_valid", a_out_valid, 0);
        check("rst_a_wrap", a_wrap, 0);
        check("rst_a_busy", a_busy, 0);
        check("rst_b_busy", b_busy, 0);
        check("rst_c_valid", c_out_valid, 0);

        // A: auto scan, dwell 0, every channel in turn with wrap on the return to 0
        a_start = 1'b1;
        tick();
        check("a_start_busy", a_busy, 1);
        check("a_start_valid", a_out_valid, 0);
        a_start = 1'b0;
        for (int k = 0; k < 18; k++) begin
            tick();
            check("a_scan_ch", a_out_ch, k % 16);
            check("a_scan_out", a_out, k & 1);
            check("a_scan_valid", a_out_valid, 1);
            check("a_scan_wrap", a_wrap, (k == 16));
        end

        // A: stop completes the final sample, then valid drops
        a_stop = 1'b1;
        tick();
        check("a_stop_busy", a_busy, 0);
        check("a_stop_last_valid", a_out_valid, 1);
        check("a_stop_last_ch", a_out_ch, 2);
        check("a_stop_last_out", a_out, 0);
        a_stop = 1'b0;
        tick();
        check("a_stop_valid", a_out_valid, 0);
        check("a_stop_hold_ch", a_out_ch, 2);

        // A: start and stop together in IDLE, stop wins
        a_start = 1'b1;
        a_stop  = 1'b1;
        tick();
        check("a_ss_busy", a_busy, 0);
        check("a_ss_valid", a_out_valid, 0);
        a_start = 1'b0;
        a_stop  = 1'b0;
        tick();
        check("a_ss_busy2", a_busy, 0);
        check("a_ss_valid2", a_out_valid, 0);

        // A: restart while RUN at channel 9
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (9) tick();
        check("a_pre_restart_ch", a_out_ch, 8);
        a_start = 1'b1;
        tick();
        check("a_restart_edge_ch", a_out_ch, 9);
        check("a_restart_busy", a_busy, 1);
        a_start = 1'b0;
        tick();
        check("a_restart_ch0", a_out_ch, 0);
        check("a_restart_valid", a_out_valid, 1);
        check("a_restart_wrap", a_wrap, 0);
        tick();
        check("a_restart_ch1", a_out_ch, 1);
        check("a_restart_out1", a_out, 1);

        // A: reset mid-scan
        rst = 1'b1;
        tick();
        check("a_mrst_out", a_out, 0);
        check("a_mrst_out_ch", a_out_ch, 0);
        check("a_mrst_valid", a_out_valid, 0);
        check("a_mrst_wrap", a_wrap, 0);
        check("a_mrst_busy", a_busy, 0);
        rst = 1'b0;

        // B: dwell 2 holds each byte three cycles, then dwell drops to 0 mid-dwell
        b_dwell = 8'd2;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("b_dwell_out", b_out, exp_b[k]);
            check("b_dwell_valid", b_out_valid, 1);
        end
        tick();
        check("b_mid_out", b_out, 8'h33);
        check("b_mid_ch", b_out_ch, 2);
        b_dwell = 8'd0;
        tick();
        check("b_low_out", b_out, 8'h33);
        tick();
        check("b_adv_out", b_out, 8'h44);
        check("b_adv_ch", b_out_ch, 3);
        tick();
        check("b_wrap_out", b_out, 8'h11);
        check("b_wrap_pulse", b_wrap, 1);
        tick();
        check("b_after_wrap_out", b_out, 8'h22);
        check("b_after_wrap", b_wrap, 0);
        b_stop = 1'b1;
        tick();
        b_stop = 1'b0;
        tick();
        check("b_stop_valid", b_out_valid, 0);

        // C: manual mode following man_sel, with clamp of index 5 to 4
        c_mode    = 1'b1;
        c_man_sel = 3'd3;
        c_start   = 1'b1;
        tick();
        check("c_start_busy", c_busy, 1);
        c_start   = 1'b0;
        c_man_sel = 3'd1;
        tick();
        check("c_man_ch3", c_out_ch, 3);
        check("c_man_out3", c_out, 8'h44);
        check("c_man_wrap3", c_wrap, 0);
        c_man_sel = 3'd2;
        tick();
        check("c_man_ch1", c_out_ch, 1);
        check("c_man_out1", c_out, 8'h22);
        c_man_sel = 3'd5;
        c_mode    = 1'b0;
        tick();
        check("c_man_ch2", c_out_ch, 2);
        check("c_man_out2", c_out, 8'h33);
        tick();
        check("c_clamp_ch", c_out_ch, 4);
        check("c_clamp_out", c_out, 8'h55);
        check("c_clamp_valid", c_out_valid, 1);
        check("c_clamp_wrap", c_wrap, 0);

`ifdef MUX_SCANNER_SKIP_MASK_EN
        // A: masked scan 0,8,15,0,8 then all-zero mask, then resume at channel 4
        a_mask  = 16'h8101;
        a_mode  = 1'b0;
        a_dwell = 8'd0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        check("m_ch0", a_out_ch, 0);
        check("m_wrap0", a_wrap, 0);
        tick();
        check("m_ch8", a_out_ch, 8);
        tick();
        check("m_ch15", a_out_ch, 15);
        check("m_wrap15", a_wrap, 0);
        tick();
        check("m_ch0b", a_out_ch, 0);
        check("m_wrap0b", a_wrap, 1);
        tick();
        check("m_ch8b", a_out_ch, 8);
        check("m_wrap8b", a_wrap, 0);
        a_mask = 16'h0000;
        tick();
        check("m_zero_valid", a_out_valid, 0);
        check("m_zero_busy", a_busy, 1);
        tick();
        check("m_zero_valid2", a_out_valid, 0);
        a_mask = 16'h0010;
        tick();
        tick();
        check("m_resume_ch", a_out_ch, 4);
        check("m_resume_valid", a_out_valid, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
